// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, sentinels and dependency-table types for the
// rename register file and its checkpoint store.
//   REG_WIDTH / EX_REG_WIDTH : architectural index width, +1 for NON_REG
//   ROB_WIDTH / EX_ROB_WIDTH : RoB tag width, +1 for NON_DEP
//   dep_t / dep_tab_t        : one dependency entry / whole table (packed)
//   clear_tag()              : retire one RoB tag from a whole table
package rf_pkg;
    localparam int REG_WIDTH    = 5;
    localparam int EX_REG_WIDTH = REG_WIDTH + 1;
    localparam int NUM_REGS     = 1 << REG_WIDTH;
    localparam int ROB_WIDTH    = 8;
    localparam int EX_ROB_WIDTH = ROB_WIDTH + 1;

    localparam logic [EX_REG_WIDTH-1:0] NON_REG = EX_REG_WIDTH'(1 << REG_WIDTH);
    localparam logic [EX_ROB_WIDTH-1:0] NON_DEP = EX_ROB_WIDTH'(1 << ROB_WIDTH);

    typedef logic [EX_ROB_WIDTH-1:0] dep_t;
    typedef dep_t [NUM_REGS-1:0]     dep_tab_t;

    localparam dep_tab_t DEP_CLEAR = {NUM_REGS{NON_DEP}};

    // Any entry still waiting on the committing tag becomes ready.
    function automatic dep_tab_t clear_tag(dep_tab_t tab, logic en, dep_t tag);
        dep_tab_t r = tab;
        for (int i = 0; i < NUM_REGS; i++)
            if (en && r[i] == tag) r[i] = NON_DEP;
        return r;
    endfunction
endpackage

// File: rtl/rf_ckpt_store.sv
// rf_ckpt_store: per-branch snapshots of the dependency table.
// Ports:
//   clk, rst (sync, active low), rdy (low holds state)
//   flush              : drop every checkpoint
//   alloc, alloc_tab   : write snapshot at tail, tail++
//   free               : release oldest checkpoint, head++ (ignored when empty)
//   clr_en, clr_tag    : commit tag cleared in every stored snapshot
//   rec_en, rec_id     : recover; tail moves to rec_id+1
//   rec_hit            : rec_id lies in [head, tail)
//   rec_tab            : snapshot rec_id with the same-cycle commit clear
//   ckpt_id, full      : tail slot, no free slot
module rf_ckpt_store
    import rf_pkg::*;
#(
    parameter int CKPT_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  flush,
    input  logic                  alloc,
    input  dep_tab_t              alloc_tab,
    input  logic                  free,
    input  logic                  clr_en,
    input  dep_t                  clr_tag,
    input  logic                  rec_en,
    input  logic [CKPT_WIDTH-1:0] rec_id,
    output logic                  rec_hit,
    output dep_tab_t              rec_tab,
    output logic [CKPT_WIDTH-1:0] ckpt_id,
    output logic                  full
);
    localparam int CKPT_DEPTH = 1 << CKPT_WIDTH;

    dep_tab_t              snap [CKPT_DEPTH];
    // Pointers carry a wrap bit so count = tail - head spans 0..CKPT_DEPTH.
    logic [CKPT_WIDTH:0]   head, tail, count, rec_off;
    logic                  alloc_ok;

    assign count    = tail - head;
    assign full     = count[CKPT_WIDTH];
    assign ckpt_id  = tail[CKPT_WIDTH-1:0];
    assign rec_off  = {1'b0, rec_id - head[CKPT_WIDTH-1:0]};
    assign rec_hit  = rec_off < count;
    assign rec_tab  = clear_tag(snap[rec_id], clr_en, clr_tag);
    assign alloc_ok = alloc && !full && !flush && !rec_en;

    always_ff @(posedge clk) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
        end else if (rdy) begin
            if (flush) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (free && count != '0) head <= head + 1'b1;
                if (rec_en)        tail <= head + rec_off + 1'b1;
                else if (alloc_ok) tail <= tail + 1'b1;
            end
        end
    end

    // Slots outside [head, tail) are never read back, so the commit clear
    // is applied to every slot rather than tracking per-slot validity.
    always_ff @(posedge clk) begin
        if (rst && rdy) begin
            for (int i = 0; i < CKPT_DEPTH; i++) begin
                if (alloc_ok && tail[CKPT_WIDTH-1:0] == CKPT_WIDTH'(i))
                    snap[i] <= alloc_tab;
                else if (clr_en)
                    snap[i] <= clear_tag(snap[i], clr_en, clr_tag);
            end
        end
    end
endmodule

// File: rtl/rename_register_file.sv
// rename_register_file: architectural register file with rename tracking
// and optional branch checkpoints (build with RF_CKPT_EN to enable them;
// without it, BURF_recover acts as a full flush).
// Ports:
//   Sys_clk, Sys_rst (sync, active low), Sys_rdy (low holds all state)
//   DPRF_*   : dispatch (rs1/rs2/rd lookup + rename, checkpoint request)
//   RFDP_*   : operand tags/values, next checkpoint id, checkpoint full
//   RoBRF_*  : commit (rd, tag, value), checkpoint free, flush
//   BURF_*   : early mispredict recover to a checkpoint id
module rename_register_file
    import rf_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int CKPT_WIDTH = 2
) (
    input  logic                    Sys_clk,
    input  logic                    Sys_rst,
    input  logic                    Sys_rdy,
    input  logic                    DPRF_en,
    input  logic [EX_REG_WIDTH-1:0] DPRF_rs1,
    input  logic [EX_REG_WIDTH-1:0] DPRF_rs2,
    input  logic [EX_REG_WIDTH-1:0] DPRF_rd,
    input  logic [ROB_WIDTH-1:0]    DPRF_RoB_index,
    input  logic                    DPRF_ckpt_req,
    output logic [EX_ROB_WIDTH-1:0] RFDP_Qj,
    output logic [EX_ROB_WIDTH-1:0] RFDP_Qk,
    output logic [XLEN-1:0]         RFDP_Vj,
    output logic [XLEN-1:0]         RFDP_Vk,
    output logic [CKPT_WIDTH-1:0]   RFDP_ckpt_id,
    output logic                    RFDP_ckpt_full,
    input  logic                    RoBRF_en,
    input  logic [ROB_WIDTH-1:0]    RoBRF_RoB_index,
    input  logic [EX_REG_WIDTH-1:0] RoBRF_rd,
    input  logic [XLEN-1:0]         RoBRF_value,
    input  logic                    RoBRF_ckpt_free,
    input  logic                    RoBRF_flush,
    input  logic                    BURF_recover,
    input  logic [CKPT_WIDTH-1:0]   BURF_ckpt_id
);
    dep_tab_t               dep, dep_next, rec_tab;
    logic [XLEN-1:0]        regs [NUM_REGS];
    logic                   flush_eff, rec_ok, disp_ok, commit_wr, rename;
    logic [REG_WIDTH-1:0]   crd, drd, idx1, idx2;
    dep_t                   ctag, dtag;

    assign crd  = RoBRF_rd[REG_WIDTH-1:0];
    assign drd  = DPRF_rd[REG_WIDTH-1:0];
    assign ctag = {1'b0, RoBRF_RoB_index};
    assign dtag = {1'b0, DPRF_RoB_index};
    assign idx1 = DPRF_rs1[REG_WIDTH-1:0];
    assign idx2 = DPRF_rs2[REG_WIDTH-1:0];

    assign commit_wr = RoBRF_en && RoBRF_rd != NON_REG && RoBRF_rd != '0;

`ifdef RF_CKPT_EN
    logic rec_hit;

    assign flush_eff = RoBRF_flush;
    assign rec_ok    = BURF_recover && !RoBRF_flush && rec_hit;

    rf_ckpt_store #(.CKPT_WIDTH(CKPT_WIDTH)) u_ckpt (
        .clk       (Sys_clk),
        .rst       (Sys_rst),
        .rdy       (Sys_rdy),
        .flush     (flush_eff),
        .alloc     (disp_ok && DPRF_ckpt_req),
        .alloc_tab (dep_next),
        .free      (RoBRF_ckpt_free),
        .clr_en    (commit_wr),
        .clr_tag   (ctag),
        .rec_en    (rec_ok),
        .rec_id    (BURF_ckpt_id),
        .rec_hit   (rec_hit),
        .rec_tab   (rec_tab),
        .ckpt_id   (RFDP_ckpt_id),
        .full      (RFDP_ckpt_full)
    );
`else
    logic unused_ckpt;

    assign unused_ckpt    = ^{BURF_ckpt_id, RoBRF_ckpt_free};
    assign flush_eff      = RoBRF_flush || BURF_recover;
    assign rec_ok         = 1'b0;
    assign rec_tab        = DEP_CLEAR;
    assign RFDP_ckpt_id   = '0;
    assign RFDP_ckpt_full = 1'b0;
`endif

    // A checkpoint request while full drops the whole dispatch.
    assign disp_ok = DPRF_en && !flush_eff && !rec_ok &&
                     !(DPRF_ckpt_req && RFDP_ckpt_full);
    assign rename  = disp_ok && DPRF_rd != NON_REG && DPRF_rd != '0;

    // Rename is applied after the commit clear so it wins on the same rd.
    always_comb begin
        dep_next = dep;
        if (commit_wr && dep[crd] == ctag) dep_next[crd] = NON_DEP;
        if (rename) dep_next[drd] = dtag;
    end

    always_ff @(posedge Sys_clk) begin
        if (!Sys_rst) begin
            dep <= DEP_CLEAR;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (Sys_rdy) begin
            if (commit_wr) regs[crd] <= RoBRF_value;
            if (flush_eff)   dep <= DEP_CLEAR;
            else if (rec_ok) dep <= rec_tab;
            else             dep <= dep_next;
        end
    end

    // Operand lookup, with bypass of the value committing this cycle.
    always_comb begin
        RFDP_Qj = dep[idx1];
        RFDP_Vj = (dep[idx1] == NON_DEP) ? regs[idx1] : '0;
        if (DPRF_rs1 == NON_REG) begin
            RFDP_Qj = NON_DEP;
            RFDP_Vj = '0;
        end else if (RoBRF_en && dep[idx1] == ctag) begin
            RFDP_Qj = NON_DEP;
            RFDP_Vj = RoBRF_value;
        end
        RFDP_Qk = dep[idx2];
        RFDP_Vk = (dep[idx2] == NON_DEP) ? regs[idx2] : '0;
        if (DPRF_rs2 == NON_REG) begin
            RFDP_Qk = NON_DEP;
            RFDP_Vk = '0;
        end else if (RoBRF_en && dep[idx2] == ctag) begin
            RFDP_Qk = NON_DEP;
            RFDP_Vk = RoBRF_value;
        end
    end
endmodule

// File: tb/tb_rename_register_file.sv
module tb_rename_register_file;
    import rf_pkg::*;

    localparam int XLEN = 32;
    localparam int CKPT_WIDTH = 2;
    localparam int S_QJ = 0, S_VJ = 1, S_QK = 2, S_VK = 3, S_FULL = 4, S_ID = 5;
    localparam logic [31:0] ND = 32'(NON_DEP);
    localparam logic [EX_REG_WIDTH-1:0] NR = NON_REG;

    logic                    Sys_clk = 1'b0;
    logic                    Sys_rst, Sys_rdy;
    logic                    DPRF_en, DPRF_ckpt_req;
    logic [EX_REG_WIDTH-1:0] DPRF_rs1, DPRF_rs2, DPRF_rd, RoBRF_rd;
    logic [ROB_WIDTH-1:0]    DPRF_RoB_index, RoBRF_RoB_index;
    logic [EX_ROB_WIDTH-1:0] RFDP_Qj, RFDP_Qk;
    logic [XLEN-1:0]         RFDP_Vj, RFDP_Vk, RoBRF_value;
    logic [CKPT_WIDTH-1:0]   RFDP_ckpt_id, BURF_ckpt_id;
    logic                    RFDP_ckpt_full, RoBRF_en, RoBRF_ckpt_free;
    logic                    RoBRF_flush, BURF_recover;

    always #5 Sys_clk = ~Sys_clk;

    rename_register_file #(.XLEN(XLEN), .CKPT_WIDTH(CKPT_WIDTH)) dut (
        .Sys_clk(Sys_clk), .Sys_rst(Sys_rst), .Sys_rdy(Sys_rdy),
        .DPRF_en(DPRF_en), .DPRF_rs1(DPRF_rs1), .DPRF_rs2(DPRF_rs2),
        .DPRF_rd(DPRF_rd), .DPRF_RoB_index(DPRF_RoB_index),
        .DPRF_ckpt_req(DPRF_ckpt_req),
        .RFDP_Qj(RFDP_Qj), .RFDP_Qk(RFDP_Qk), .RFDP_Vj(RFDP_Vj), .RFDP_Vk(RFDP_Vk),
        .RFDP_ckpt_id(RFDP_ckpt_id), .RFDP_ckpt_full(RFDP_ckpt_full),
        .RoBRF_en(RoBRF_en), .RoBRF_RoB_index(RoBRF_RoB_index),
        .RoBRF_rd(RoBRF_rd), .RoBRF_value(RoBRF_value),
        .RoBRF_ckpt_free(RoBRF_ckpt_free), .RoBRF_flush(RoBRF_flush),
        .BURF_recover(BURF_recover), .BURF_ckpt_id(BURF_ckpt_id)
    );

    typedef struct { int sel; logic [31:0] val; } exp_t;
    exp_t sb[$];
    int checks = 0, errors = 0;

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] act_of(int sel);
        case (sel)
            S_QJ:    return 32'(RFDP_Qj);
            S_VJ:    return RFDP_Vj;
            S_QK:    return 32'(RFDP_Qk);
            S_VK:    return RFDP_Vk;
            S_FULL:  return 32'(RFDP_ckpt_full);
            default: return 32'(RFDP_ckpt_id);
        endcase
    endfunction

    function automatic string name_of(int sel);
        case (sel)
            S_QJ: return "Qj";  S_VJ: return "Vj";
            S_QK: return "Qk";  S_VK: return "Vk";
            S_FULL: return "ckpt_full";
            default: return "ckpt_id";
        endcase
    endfunction

    task automatic expect_out(int sel, logic [31:0] v);
        exp_t e;
        e.sel = sel;
        e.val = v;
        sb.push_back(e);
    endtask

    // Let the combinational outputs settle, then score every pending entry.
    task automatic drain();
        exp_t e;
        #2;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(name_of(e.sel), act_of(e.sel), e.val);
        end
    endtask

    task automatic idle();
        Sys_rdy = 1'b1;
        DPRF_en = 1'b0; DPRF_ckpt_req = 1'b0;
        DPRF_rs1 = NR; DPRF_rs2 = NR; DPRF_rd = NR; DPRF_RoB_index = '0;
        RoBRF_en = 1'b0; RoBRF_RoB_index = '0; RoBRF_rd = NR; RoBRF_value = '0;
        RoBRF_ckpt_free = 1'b0; RoBRF_flush = 1'b0;
        BURF_recover = 1'b0; BURF_ckpt_id = '0;
    endtask

    task automatic tick();
        @(posedge Sys_clk);
        #1;
        idle();
    endtask

    task automatic disp(logic [EX_REG_WIDTH-1:0] rd, logic [ROB_WIDTH-1:0] tag, logic ck);
        DPRF_en = 1'b1; DPRF_rd = rd; DPRF_RoB_index = tag; DPRF_ckpt_req = ck;
    endtask

    task automatic commit(logic [EX_REG_WIDTH-1:0] rd, logic [ROB_WIDTH-1:0] tag,
                          logic [XLEN-1:0] val);
        RoBRF_en = 1'b1; RoBRF_rd = rd; RoBRF_RoB_index = tag; RoBRF_value = val;
    endtask

    initial begin
        Sys_rst = 1'b0;
        idle();
        tick(); tick();
        Sys_rst = 1'b1;
        tick();

        // Reset state
        DPRF_rs1 = 6'd5; DPRF_rs2 = NR;
        expect_out(S_QJ, ND); expect_out(S_VJ, 0);
        expect_out(S_QK, ND); expect_out(S_VK, 0);
        expect_out(S_FULL, 0); expect_out(S_ID, 0);
        drain();

        // Rename, then commit bypass on the same cycle, then stored value
        disp(6'd3, 8'd7, 1'b0);
        tick();
        DPRF_rs1 = 6'd3; DPRF_rs2 = 6'd3;
        expect_out(S_QJ, 32'd7); expect_out(S_VJ, 0);
        drain();
        commit(6'd3, 8'd7, 32'hDEAD);
        expect_out(S_QJ, ND); expect_out(S_VJ, 32'hDEAD);
        expect_out(S_QK, ND); expect_out(S_VK, 32'hDEAD);
        drain();
        tick();
        DPRF_rs1 = 6'd3;
        expect_out(S_QJ, ND); expect_out(S_VJ, 32'hDEAD);
        drain();

        // Same-cycle commit and re-rename of rd 4: rename wins, reg written
        disp(6'd4, 8'd2, 1'b0);
        tick();
        commit(6'd4, 8'd2, 32'h1234);
        disp(6'd4, 8'd9, 1'b0);
        tick();
        DPRF_rs1 = 6'd4;
        expect_out(S_QJ, 32'd9); expect_out(S_VJ, 0);
        drain();
        RoBRF_flush = 1'b1;
        tick();
        DPRF_rs1 = 6'd4;
        expect_out(S_QJ, ND); expect_out(S_VJ, 32'h1234);
        drain();

        // Register 0 is never renamed or written
        disp(6'd0, 8'd3, 1'b0);
        commit(6'd0, 8'd3, 32'h55);
        tick();
        DPRF_rs1 = 6'd0;
        expect_out(S_QJ, ND); expect_out(S_VJ, 0);
        drain();

        // Sys_rdy low holds everything
        Sys_rdy = 1'b0;
        disp(6'd6, 8'd1, 1'b0);
        commit(6'd5, 8'd0, 32'h77);
        tick();
        DPRF_rs1 = 6'd6; DPRF_rs2 = 6'd5;
        expect_out(S_QJ, ND); expect_out(S_VK, 0);
        drain();

`ifdef RF_CKPT_EN
        // Checkpoint 0 after rd1<-5, rename rd1<-6, recover to 0
        expect_out(S_ID, 0); expect_out(S_FULL, 0);
        disp(6'd1, 8'd5, 1'b1);
        drain();
        tick();
        expect_out(S_ID, 1);
        disp(6'd1, 8'd6, 1'b0);
        drain();
        tick();
        DPRF_rs1 = 6'd1;
        expect_out(S_QJ, 32'd6);
        BURF_recover = 1'b1; BURF_ckpt_id = 2'd0;
        drain();
        tick();
        DPRF_rs1 = 6'd1;
        expect_out(S_QJ, 32'd5); expect_out(S_ID, 1); expect_out(S_FULL, 0);
        drain();

        // Commit of tag 5 clears it inside the live checkpoint
        disp(6'd1, 8'd8, 1'b0);
        tick();
        commit(6'd1, 8'd5, 32'hBEEF);
        tick();
        BURF_recover = 1'b1; BURF_ckpt_id = 2'd0;
        tick();
        DPRF_rs1 = 6'd1;
        expect_out(S_QJ, ND); expect_out(S_VJ, 32'hBEEF);
        drain();

        // Fill the store; request while full is dropped entirely
        for (int k = 1; k < 4; k++) begin
            expect_out(S_ID, 32'(k)); expect_out(S_FULL, 0);
            disp(NR, 8'd0, 1'b1);
            drain();
            tick();
        end
        expect_out(S_FULL, 1); expect_out(S_ID, 0);
        disp(6'd2, 8'd11, 1'b1);
        drain();
        tick();
        DPRF_rs1 = 6'd2;
        expect_out(S_QJ, ND); expect_out(S_FULL, 1);
        drain();
        // Free and alloc together at full: free lands, alloc refused
        RoBRF_ckpt_free = 1'b1;
        disp(6'd2, 8'd12, 1'b1);
        tick();
        DPRF_rs1 = 6'd2;
        expect_out(S_QJ, ND); expect_out(S_FULL, 0); expect_out(S_ID, 0);
        drain();
        // Head is now 1: recover to id 0 is out of range and ignored
        BURF_recover = 1'b1; BURF_ckpt_id = 2'd0;
        disp(6'd2, 8'd13, 1'b0);
        tick();
        DPRF_rs1 = 6'd2;
        expect_out(S_QJ, 32'd13); expect_out(S_ID, 0); expect_out(S_FULL, 0);
        drain();
        RoBRF_flush = 1'b1;
        tick();
        DPRF_rs1 = 6'd2;
        expect_out(S_QJ, ND); expect_out(S_FULL, 0); expect_out(S_ID, 0);
        drain();
`else
        // Without checkpoints: requests ignored, recover clears everything
        disp(6'd1, 8'd5, 1'b1);
        expect_out(S_FULL, 0); expect_out(S_ID, 0);
        drain();
        tick();
        DPRF_rs1 = 6'd1;
        expect_out(S_QJ, 32'd5); expect_out(S_ID, 0);
        drain();
        BURF_recover = 1'b1;
        RoBRF_ckpt_free = 1'b1;
        disp(6'd2, 8'd3, 1'b0);
        tick();
        DPRF_rs1 = 6'd1; DPRF_rs2 = 6'd2;
        expect_out(S_QJ, ND); expect_out(S_QK, ND);
        expect_out(S_ID, 0); expect_out(S_FULL, 0);
        drain();
`endif

        // Reset overrides flush/recover/dispatch in the same cycle
        disp(6'd9, 8'd4, 1'b1);
        tick();
        Sys_rst = 1'b0;
        RoBRF_flush = 1'b1; BURF_recover = 1'b1;
        disp(6'd3, 8'd1, 1'b0);
        tick();
        Sys_rst = 1'b1;
        DPRF_rs1 = 6'd3; DPRF_rs2 = 6'd9;
        expect_out(S_QJ, ND); expect_out(S_VJ, 0);
        expect_out(S_QK, ND); expect_out(S_ID, 0); expect_out(S_FULL, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rename_register_file.md
# rename_register_file

Architectural register file with rename-dependency tracking and branch checkpoints. It is the parametrised successor of the single-snapshot-free register file. It sits between Dispatcher, RoB and Branch Unit:
- serves operand tag/value lookups at dispatch;
- retires committed values;
- snapshots the dependency table per in-flight branch, so an early mispredict restores renaming in one cycle instead of flushing every dependency.

## Interface
- REG_WIDTH, 5: architectural register index width; EX_REG_WIDTH = REG_WIDTH+1, NON_REG = 1<<REG_WIDTH.
- ROB_WIDTH, 8: RoB index width; EX_ROB_WIDTH = ROB_WIDTH+1, NON_DEP = 1<<ROB_WIDTH.
- XLEN, 32: data width.
- CKPT_WIDTH, 2: checkpoint id width; CKPT_DEPTH = 1<<CKPT_WIDTH.

Ports:
- Sys_clk in 1: clock, all state on posedge.
- Sys_rst in 1: synchronous, active-low reset.
- Sys_rdy in 1: low holds all state.
- DPRF_en in 1: dispatch valid.
- DPRF_rs1, DPRF_rs2, DPRF_rd in EX_REG_WIDTH: sources/destination, NON_REG = none.
- DPRF_RoB_index in ROB_WIDTH: RoB tag for rd.
- DPRF_ckpt_req in 1: dispatching instruction is a branch and needs a checkpoint.
- RFDP_Qj, RFDP_Qk out EX_ROB_WIDTH: source tags, NON_DEP = ready.
- RFDP_Vj, RFDP_Vk out XLEN: source values, valid when tag is NON_DEP.
- RFDP_ckpt_id out CKPT_WIDTH: id the next checkpoint receives (tail).
- RFDP_ckpt_full out 1: no free checkpoint.
- RoBRF_en in 1: commit valid.
- RoBRF_RoB_index in ROB_WIDTH: tag of the committing instruction.
- RoBRF_rd in EX_REG_WIDTH: destination of the committing instruction.
- RoBRF_value in XLEN: committed value.
- RoBRF_ckpt_free in 1: committing branch releases the oldest checkpoint (head).
- RoBRF_flush in 1: full pipeline flush.
- BURF_recover in 1: early mispredict from Branch Unit.
- BURF_ckpt_id in CKPT_WIDTH: checkpoint of the mispredicted branch.

## Operation
- Lookup is combinational:
  - rs = NON_REG gives Q = NON_DEP, V = 0.
  - If RoBRF_en and dep[rs] == RoBRF_RoB_index, the commit is bypassed: Q = NON_DEP, V = RoBRF_value.
  - Otherwise Q = dep[rs]; V = reg[rs] if dep[rs] == NON_DEP, else 0.
- Commit, when RoBRF_en and rd is neither NON_REG nor 0:
  - reg[rd] <= value.
  - dep[rd] <= NON_DEP only if it still equals the commit tag and the same-cycle dispatch does not rename rd.
  - Every valid checkpoint entry equal to the commit tag is cleared to NON_DEP.
- Rename: DPRF_en with rd neither NON_REG nor 0 sets dep[rd] <= DPRF_RoB_index. The same-cycle dispatch rename wins over the commit clear.
- Checkpoint allocation, on DPRF_en & DPRF_ckpt_req & !full:
  - ckpt[tail] <= next-state dep table, including this cycle's rename and commit clear.
  - tail++, count++.
- DPRF_en with DPRF_ckpt_req while full is a protocol error; the whole dispatch is ignored (no rename, no checkpoint). The Dispatcher stalls on RFDP_ckpt_full.
- RoBRF_ckpt_free: head++, count--. Ignored when count == 0.
- Recover (BURF_recover, no flush):
  - dep <= ckpt[BURF_ckpt_id] with the same-cycle commit clear applied.
  - tail <= BURF_ckpt_id+1; count <= (BURF_ckpt_id+1-head) mod 2·CKPT_DEPTH using wrap-bit pointers. The branch keeps its own checkpoint until it commits.
  - Dispatch is ignored this cycle.
  - A recover to an id outside [head, tail) is ignored.
- Flush (RoBRF_flush):
  - All dep <= NON_DEP; head = tail = count = 0.
  - Dispatch and recover are ignored this cycle.
  - The same-cycle commit still writes reg.
- Priority: reset > !Sys_rdy (hold) > flush > recover > normal. Free and alloc may occur in the same cycle; full is evaluated on registered count, so alloc at full is refused even when a free occurs that cycle.
- Register 0 is never written and always reads 0 / NON_DEP.

## Timing
- Lookups have zero latency. All state updates take effect at the next posedge.
- Restored dependencies are visible to lookups one cycle after recover.
- Reset values:
  - reg = 0, dep = NON_DEP, checkpoints invalid, head = tail = count = 0.
  - Outputs: RFDP_ckpt_full = 0, RFDP_ckpt_id = 0, Q = NON_DEP, V = 0.
- A reset asserted mid-recovery or mid-flush overrides both in that cycle.

## Configuration
- RF_CKPT_EN defined: the checkpoint store, allocation, free and recover logic are built as described.
- RF_CKPT_EN undefined:
  - No checkpoint storage is built.
  - RFDP_ckpt_full = 0 and RFDP_ckpt_id = 0.
  - DPRF_ckpt_req and RoBRF_ckpt_free are ignored.
  - BURF_recover behaves exactly as RoBRF_flush: all dependencies are cleared.

## Structure
- Shared package rf_pkg holds REG_WIDTH, ROB_WIDTH, NON_REG, NON_DEP and the dep-table entry type.
- Sub-module rf_ckpt_store holds the snapshot array, the head/tail wrap-bit pointers, count/full, per-commit clearing of snapshot entries, and the restore read port.

## Test plan
- Reset, then read rs1 = 5, rs2 = NON_REG -> Q = NON_DEP both, V = 0 both, ckpt_full = 0.
- Dispatch rd = 3 with tag 7, next cycle commit tag 7 value 0xDEAD while rs1 = 3 -> same cycle Qj = NON_DEP, Vj = 0xDEAD; next cycle reg[3] = 0xDEAD.
- Same-cycle commit rd = 4 tag 2 and dispatch rd = 4 tag 9 -> dep[4] = 9, reg[4] updated.
- Branch checkpoint id 0 taken after rd = 1 tag 5, then rd = 1 tag 6, then BURF_recover id 0 -> dep[1] = 5, tail = 1, count = 1.
- Commit tag 5 while checkpoint 0 is live, then recover id 0 -> dep[1] = NON_DEP.
- Allocate CKPT_DEPTH checkpoints -> ckpt_full = 1; another ckpt_req dispatch is ignored. RoBRF_flush -> count = 0, all dep = NON_DEP.
